// File: rtl/ex_wb_pipe_2l.sv
// Two-lane EX1->EX2 writeback staging: combinational EX1 forward pairs,
// registered EX2 commit pairs with late-result muxing, and load-use interlock.
module ex_wb_pipe_2l #(
  parameter logic [5:0] ZZR_ID = 6'h3F,
  parameter int         CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic [5:0]       exIdRnA,
  input  logic [63:0]      exValRnA,
  input  logic             exHeldA,
  input  logic [5:0]       exIdRnB,
  input  logic [63:0]      exValRnB,
  input  logic             exHeldB,
  input  logic [63:0]      ex2ValA,
  input  logic [63:0]      ex2ValB,
  input  logic [5:0]       decIdRs,
  input  logic [5:0]       decIdRt,
  input  logic [5:0]       decIdRu,
  input  logic [5:0]       decIdRv,
  output logic [5:0]       regIdRnA1,
  output logic [63:0]      regValRnA1,
  output logic [5:0]       regIdRnB1,
  output logic [63:0]      regValRnB1,
  output logic [5:0]       regIdRnA2,
  output logic [63:0]      regValRnA2,
  output logic [5:0]       regIdRnB2,
  output logic [63:0]      regValRnB2,
  output logic             stall,
  output logic [CNT_W-1:0] stallCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]       id2a_q,   id2a_d,   id2b_q,   id2b_d;
  logic [63:0]      val2a_q,  val2a_d,  val2b_q,  val2b_d;
  logic             held2a_q, held2a_d, held2b_q, held2b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hit_a_s, hit_b_s, stall_s;

  // Load-use detect: only an EX1 result still pending with a real destination blocks decode.
  always_comb begin
    hit_a_s = 1'b0;
    hit_b_s = 1'b0;
    if (exHeldA && (exIdRnA != ZZR_ID)) begin
      hit_a_s = (decIdRs == exIdRnA) || (decIdRt == exIdRnA) ||
                (decIdRu == exIdRnA) || (decIdRv == exIdRnA);
    end else begin
      hit_a_s = 1'b0;
    end
    if (exHeldB && (exIdRnB != ZZR_ID)) begin
      hit_b_s = (decIdRs == exIdRnB) || (decIdRt == exIdRnB) ||
                (decIdRu == exIdRnB) || (decIdRv == exIdRnB);
    end else begin
      hit_b_s = 1'b0;
    end
    stall_s = hit_a_s || hit_b_s;
  end

  // Next-state for EX2 staging and the interlock counter; hold freezes everything.
  always_comb begin
    id2a_d      = id2a_q;
    val2a_d     = val2a_q;
    held2a_d    = held2a_q;
    id2b_d      = id2b_q;
    val2b_d     = val2b_q;
    held2b_d    = held2b_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      id2a_d   = exIdRnA;
      val2a_d  = exValRnA;
      held2a_d = exHeldA;
      id2b_d   = exIdRnB;
      val2b_d  = exValRnB;
      held2b_d = exHeldB;
      if (stall_s) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset wins over hold and drops any pending late result.
  always_ff @(posedge clock) begin
    if (reset) begin
      id2a_q      <= ZZR_ID;
      val2a_q     <= 64'h0;
      held2a_q    <= 1'b0;
      id2b_q      <= ZZR_ID;
      val2b_q     <= 64'h0;
      held2b_q    <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      id2a_q      <= id2a_d;
      val2a_q     <= val2a_d;
      held2a_q    <= held2a_d;
      id2b_q      <= id2b_d;
      val2b_q     <= val2b_d;
      held2b_q    <= held2b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign regIdRnA1  = exHeldA ? ZZR_ID : exIdRnA;
  assign regValRnA1 = exValRnA;
  assign regIdRnB1  = exHeldB ? ZZR_ID : exIdRnB;
  assign regValRnB1 = exValRnB;

  assign regIdRnA2  = id2a_q;
  assign regValRnA2 = held2a_q ? ex2ValA : val2a_q;
  assign regIdRnB2  = id2b_q;
  assign regValRnB2 = held2b_q ? ex2ValB : val2b_q;

  assign stall      = stall_s;
  assign stallCnt   = stall_cnt_q;

endmodule

// File: doc/ex_wb_pipe_2l.md
Name: ex_wb_pipe_2l

Overview:
- Two-lane EX1->EX2 writeback staging block that drives the destination ID/value pairs consumed by the 4R/2W GPR file.
- Produces the EX1 forwarding pair, the registered EX2 commit pair and a load-use interlock stall.
- Sits between the lane execute units (ALU/memory) and the register file, alongside decode.

Parameters:
ZZR_ID, 6'h3F, null destination ID; must equal JX2_GR_ZZR.
CNT_W, 32, width of the interlock cycle counter.

Ports:
clock  in  1  core clock
reset  in  1  synchronous reset, active-high
hold  in  1  pipeline hold (cache miss etc.); freezes all state
exIdRnA  in  6  EX1 lane-1 destination ID (ZZR_ID = no write)
exValRnA  in  64  EX1 lane-1 result
exHeldA  in  1  lane-1 result not ready in EX1; supplied in EX2 via ex2ValA
exIdRnB / exValRnB / exHeldB  in  6/64/1  lane-2 equivalents
ex2ValA  in  64  lane-1 late result (load data), valid in EX2
ex2ValB  in  64  lane-2 late result
decIdRs, decIdRt, decIdRu, decIdRv  in  6 each  decode-stage source IDs
regIdRnA1  out  6  EX1 forward ID, lane 1
regValRnA1  out  64  EX1 forward value, lane 1
regIdRnB1 / regValRnB1  out  6/64  EX1 forward pair, lane 2
regIdRnA2  out  6  EX2 commit ID, lane 1
regValRnA2  out  64  EX2 commit value, lane 1
regIdRnB2 / regValRnB2  out  6/64  EX2 commit pair, lane 2
stall  out  1  load-use interlock request to decode
stallCnt  out  CNT_W  count of interlock cycles

Behaviour:
- EX1 forward pairs are combinational.
  - regIdRnA1 = exHeldA ? ZZR_ID : exIdRnA.
  - regValRnA1 = exValRnA.
  - Lane 2 follows the same rules.
  - A held result is never forwarded from EX1.
- EX2 registers per lane: id2, val2, held2.
  - On posedge with !reset && !hold, they load exIdRn*, exValRn*, exHeld*.
  - With hold=1, all registers keep their value, including stallCnt.
- EX2 commit pair:
  - regIdRnA2 = id2A.
  - regValRnA2 = held2A ? ex2ValA : val2A.
  - Lane 2 follows the same rules.
  - Latency: an EX1 input appears on the *2 ports exactly 1 non-held cycle later.
- stall is combinational.
  - It is 1 iff any decId* equals exIdRnA while exHeldA=1 and exIdRnA!=ZZR_ID, or the same condition holds for lane B.
  - Held entries in EX2 do not stall; the register file forwards them from the *2 ports.
  - stall is computed independent of hold.
  - Decode inserts the bubble; this block keeps advancing EX1->EX2.
- stallCnt increments by 1 on posedge when stall && !hold && !reset.
  - It wraps from all-ones to 0.
- Reset, synchronous and taking priority over hold:
  - id2A = id2B = ZZR_ID; val2A = val2B = 0; held2A = held2B = 0; stallCnt = 0.
  - After reset: *2 ports read ZZR_ID / 0; stall depends only on current inputs.
  - Reset mid-load discards the pending held result; no write reaches the GPR.
- Same destination on both lanes in one cycle is not legal for issue.
  - If it occurs, both pairs are still emitted unchanged.
  - Resolution is left to the register file, where lane B commits last.
- exHeld* with ID ZZR_ID is ignored for stall, but held2 is still latched.
  - The commit ID remains ZZR_ID, so no write occurs.
- No other storage. Outputs carry no X after reset.

Test Plan:
- Reset with hold=1 -> next cycle regIdRnA2=regIdRnB2=6'h3F, regValRnA2=0, stallCnt=0 (reset beats hold).
- Lane A ALU op: exIdRnA=6'h05, exValRnA=64'h1234, exHeldA=0.
  - Same cycle: regIdRnA1=05, regValRnA1=1234.
  - Next cycle: regIdRnA2=05, regValRnA2=1234.
- Load-use on lane B: exIdRnB=6'h09, exHeldB=1, decIdRt=09.
  - Same cycle: stall=1 and regIdRnB1=3F.
  - Next cycle with ex2ValB=64'hDEAD: regIdRnB2=09, regValRnB2=DEAD, and stallCnt incremented by 1.
- Hold freeze: EX2 holds ID 05; assert hold for 3 cycles while changing exIdRnA=07.
  - regIdRnA2 stays 05 throughout.
  - stallCnt is unchanged even with stall=1.
  - After release, regIdRnA2=07 one cycle later.
- ZZR handling: exIdRnA=3F, exHeldA=1, decIdRs=3F -> stall=0, and regIdRnA2=3F the next cycle.
- Counter wrap: force 2^32-1 counted stall cycles (or CNT_W=4 build with 15 cycles), then one more stall cycle -> stallCnt=0.
